// File: rtl/arc4_if.sv
// ARC4 encryptor bus: start/ready handshake plus S, PT and CT memory ports.
// master = encryptor side (drives the memory buses), slave = environment side.
interface arc4_if #(
    parameter int unsigned KEY_BYTES = 3
);
    logic                     en;
    logic                     rdy;
    logic [8*KEY_BYTES-1:0]   key;
    logic [7:0]               s_addr;
    logic [7:0]               s_rddata;
    logic [7:0]               s_wrdata;
    logic                     s_wren;
    logic [7:0]               pt_addr;
    logic [7:0]               pt_rddata;
    logic [7:0]               ct_addr;
    logic [7:0]               ct_wrdata;
    logic                     ct_wren;

    modport master (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );

    modport slave (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: S-box init, key schedule and keystream generation over an external
// 256x8 S memory; reads a length-prefixed plaintext and writes a length-prefixed ciphertext.
// All memories have one cycle of synchronous read latency, so every read uses an
// "address presented" state followed by a "data valid" state.
module arc4_encrypt #(
    parameter int unsigned KEY_BYTES = 3
) (
    input logic    clk,
    input logic    rst_n,
    arc4_if.master bus
);

    typedef enum logic [4:0] {
        StIdle,
        StInit,
        StKsaRdI,
        StKsaLatI,
        StKsaRdJ,
        StKsaLatJ,
        StKsaWrI,
        StKsaWrJ,
        StLenRd,
        StLenLat,
        StLenWr,
        StPrgaRdI,
        StPrgaLatI,
        StPrgaRdJ,
        StPrgaLatJ,
        StPrgaWrI,
        StPrgaWrJ,
        StPrgaRdP,
        StPrgaLatP,
        StPrgaWrCt,
        StDone
    } state_e;

    state_e                 state_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             kidx_q;
    logic [8:0]             cnt_q;   // 9 bits so INIT can count to 256 without aliasing
    logic [7:0]             i_q;
    logic [7:0]             j_q;
    logic [7:0]             si_q;
    logic [7:0]             sj_q;
    logic [7:0]             len_q;
    logic [7:0]             pt_q;

    logic                   rdy_q;
    logic [7:0]             s_addr_q;
    logic [7:0]             s_wrdata_q;
    logic                   s_wren_q;
    logic [7:0]             pt_addr_q;
    logic [7:0]             ct_addr_q;
    logic [7:0]             ct_wrdata_q;
    logic                   ct_wren_q;

    logic [7:0]             key_byte;
    logic [7:0]             kidx_next;
    logic [7:0]             j_ksa;
    logic [7:0]             j_prga;
    logic [7:0]             pad_addr;

    // Key byte for the current KSA step; byte 0 is the most significant byte of the key.
    always_comb begin
        key_byte = 8'h00;
        for (int unsigned n = 0; n < KEY_BYTES; n++) begin
            if (kidx_q == 8'(n)) key_byte = key_q[8*(KEY_BYTES-1-n) +: 8];
        end
        kidx_next = (kidx_q == 8'(KEY_BYTES - 1)) ? 8'h00 : kidx_q + 8'd1;
    end

    // Index arithmetic, all mod 256.
    always_comb begin
        j_ksa    = j_q + bus.s_rddata + key_byte;
        j_prga   = j_q + bus.s_rddata;
        pad_addr = si_q + sj_q;
    end

    assign bus.rdy       = rdy_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wrdata  = s_wrdata_q;
    assign bus.s_wren    = s_wren_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.ct_wrdata = ct_wrdata_q;
    assign bus.ct_wren   = ct_wren_q;

    // Main sequencer: every output is registered and set for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            key_q       <= '0;
            kidx_q      <= 8'h00;
            cnt_q       <= 9'd0;
            i_q         <= 8'h00;
            j_q         <= 8'h00;
            si_q        <= 8'h00;
            sj_q        <= 8'h00;
            len_q       <= 8'h00;
            pt_q        <= 8'h00;
            rdy_q       <= 1'b1;
            s_addr_q    <= 8'h00;
            s_wrdata_q  <= 8'h00;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= 8'h00;
            ct_addr_q   <= 8'h00;
            ct_wrdata_q <= 8'h00;
            ct_wren_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.en) begin
                        key_q      <= bus.key;
                        rdy_q      <= 1'b0;
                        s_addr_q   <= 8'h00;
                        s_wrdata_q <= 8'h00;
                        s_wren_q   <= 1'b1;
                        ct_wren_q  <= 1'b0;
                        cnt_q      <= 9'd1;
                        state_q    <= StInit;
                    end
                end
                StInit: begin
                    if (cnt_q == 9'd256) begin
                        s_wren_q <= 1'b0;
                        s_addr_q <= 8'h00;
                        i_q      <= 8'h00;
                        j_q      <= 8'h00;
                        kidx_q   <= 8'h00;
                        cnt_q    <= 9'd0;
                        state_q  <= StKsaRdI;
                    end else begin
                        s_addr_q   <= cnt_q[7:0];
                        s_wrdata_q <= cnt_q[7:0];
                        cnt_q      <= cnt_q + 9'd1;
                    end
                end
                StKsaRdI: state_q <= StKsaLatI;
                StKsaLatI: begin
                    si_q     <= bus.s_rddata;
                    j_q      <= j_ksa;
                    s_addr_q <= j_ksa;
                    kidx_q   <= kidx_next;
                    state_q  <= StKsaRdJ;
                end
                StKsaRdJ: state_q <= StKsaLatJ;
                StKsaLatJ: begin
                    // Swap values come from registers; S is never re-read mid-swap.
                    sj_q       <= bus.s_rddata;
                    s_addr_q   <= i_q;
                    s_wrdata_q <= bus.s_rddata;
                    s_wren_q   <= 1'b1;
                    state_q    <= StKsaWrI;
                end
                StKsaWrI: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    state_q    <= StKsaWrJ;
                end
                StKsaWrJ: begin
                    s_wren_q <= 1'b0;
                    if (cnt_q == 9'd255) begin
                        pt_addr_q <= 8'h00;
                        state_q   <= StLenRd;
                    end else begin
                        cnt_q    <= cnt_q + 9'd1;
                        i_q      <= i_q + 8'd1;
                        s_addr_q <= i_q + 8'd1;
                        state_q  <= StKsaRdI;
                    end
                end
                StLenRd: state_q <= StLenLat;
                StLenLat: begin
                    len_q       <= bus.pt_rddata;
                    ct_addr_q   <= 8'h00;
                    ct_wrdata_q <= bus.pt_rddata;
                    ct_wren_q   <= 1'b1;
                    state_q     <= StLenWr;
                end
                StLenWr: begin
                    ct_wren_q <= 1'b0;
                    i_q       <= 8'd1;
                    j_q       <= 8'h00;
                    cnt_q     <= 9'd1;
                    if (len_q == 8'h00) begin
                        state_q <= StDone;
                    end else begin
                        s_addr_q  <= 8'd1;
                        pt_addr_q <= 8'd1;
                        state_q   <= StPrgaRdI;
                    end
                end
                StPrgaRdI: state_q <= StPrgaLatI;
                StPrgaLatI: begin
                    si_q     <= bus.s_rddata;
                    j_q      <= j_prga;
                    s_addr_q <= j_prga;
                    pt_q     <= bus.pt_rddata;
                    state_q  <= StPrgaRdJ;
                end
                StPrgaRdJ: state_q <= StPrgaLatJ;
                StPrgaLatJ: begin
                    sj_q       <= bus.s_rddata;
                    s_addr_q   <= i_q;
                    s_wrdata_q <= bus.s_rddata;
                    s_wren_q   <= 1'b1;
                    state_q    <= StPrgaWrI;
                end
                StPrgaWrI: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    state_q    <= StPrgaWrJ;
                end
                StPrgaWrJ: begin
                    // Pad read is issued only after both swap writes, so it sees post-swap S.
                    s_wren_q <= 1'b0;
                    s_addr_q <= pad_addr;
                    state_q  <= StPrgaRdP;
                end
                StPrgaRdP: state_q <= StPrgaLatP;
                StPrgaLatP: begin
                    ct_addr_q   <= cnt_q[7:0];
                    ct_wrdata_q <= bus.s_rddata ^ pt_q;
                    ct_wren_q   <= 1'b1;
                    state_q     <= StPrgaWrCt;
                end
                StPrgaWrCt: begin
                    ct_wren_q <= 1'b0;
                    if (cnt_q[7:0] == len_q) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q     <= cnt_q + 9'd1;
                        i_q       <= i_q + 8'd1;
                        s_addr_q  <= i_q + 8'd1;
                        pt_addr_q <= cnt_q[7:0] + 8'd1;
                        state_q   <= StPrgaRdI;
                    end
                end
                StDone: begin
                    s_wren_q  <= 1'b0;
                    ct_wren_q <= 1'b0;
                    rdy_q     <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
